// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract whose carry chain is cut into STAGES registered segments,
// with valid/ready on both sides. Define PIPELINED_ADDSUB_OVF_EN to add the ovf output.
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   S
`ifdef PIPELINED_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int SEG = WIDTH / STAGES;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : stg
            localparam int LO  = k * SEG;
            localparam int REM = WIDTH - LO;   // operand bits not yet summed on entry
            logic [REM-1:0]    a_in, b_in;
            logic              c_in, v_in, adv;
            logic [SEG:0]      part;
            logic [LO+SEG-1:0] s_d, s_q;
            logic              c_q, v_q;

            if (k == 0) begin : src
                // subtraction runs as F + ~G + ~Cin, so S[WIDTH] reads as not-borrow
                assign a_in = F;
                assign b_in = sub ? ~G : G;
                assign c_in = sub ? ~Cin : Cin;
                assign v_in = in_valid;
                assign s_d  = part[SEG-1:0];
            end else begin : src
                assign a_in = stg[k-1].rem.a_q;
                assign b_in = stg[k-1].rem.b_q;
                assign c_in = stg[k-1].c_q;
                assign v_in = stg[k-1].v_q;
                assign s_d  = {part[SEG-1:0], stg[k-1].s_q};
            end

            // a stage may load if the next one moves or it holds nothing
            if (k == STAGES - 1) begin : nxt
                assign adv = out_ready || !v_q;
            end else begin : nxt
                assign adv = stg[k+1].adv || !v_q;
            end

            assign part = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + (SEG+1)'(c_in);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (adv) begin
                    v_q <= v_in;
                    if (v_in) begin
                        c_q <= part[SEG];
                        s_q <= s_d;
                    end
                end
            end

            if (k < STAGES - 1) begin : rem
                logic [REM-SEG-1:0] a_q, b_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (adv && v_in) begin
                        a_q <= a_in[REM-1:SEG];
                        b_q <= b_in[REM-1:SEG];
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = stg[0].adv;
    assign out_valid = stg[STAGES-1].v_q;
    assign S         = {stg[STAGES-1].c_q, stg[STAGES-1].s_q};

`ifdef PIPELINED_ADDSUB_OVF_EN
    // carry into the MSB is recovered as sum ^ a ^ b at that bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (stg[STAGES-1].adv && stg[STAGES-1].v_in)
            ovf <= stg[STAGES-1].part[SEG] ^ stg[STAGES-1].part[SEG-1]
                 ^ stg[STAGES-1].a_in[SEG-1] ^ stg[STAGES-1].b_in[SEG-1];
    end
`endif
endmodule
